// File: rtl/signed_adder_pkg.sv
// ----------------------------------------------------------------------------
// signed_adder_pkg
//   Shared constants and helpers for the sign-magnitude adder.
//   - WIDTH_DEFAULT : default magnitude width of each operand
//   - sum_width()   : width of the signed result (WIDTH + 2)
//   - HELPER_W      : working width of the conversion helper
//   - sm_to_tc_fn() : sign-magnitude to two's complement conversion
// ----------------------------------------------------------------------------
package signed_adder_pkg;

    localparam int WIDTH_DEFAULT = 4;

    // The conversion helper works at a fixed width and callers narrow the
    // result. This lets one package function serve any WIDTH, provided
    // WIDTH + 2 <= HELPER_W.
    localparam int HELPER_W = 32;

    // Two extra bits: one for the carry out of |A| + |B| and one for the sign.
    function automatic int sum_width(input int width);
        return width + 2;
    endfunction

    // Negative zero needs no special case: -0 is 0 in two's complement.
    function automatic logic signed [HELPER_W-1:0] sm_to_tc_fn(
        input logic [HELPER_W-1:0] mag,
        input logic                neg
    );
        logic signed [HELPER_W-1:0] pos;
        pos = $signed(mag);
        return neg ? -pos : pos;
    endfunction

endpackage

// File: rtl/signed_adder_sm_to_tc.sv
// ----------------------------------------------------------------------------
// sm_to_tc
//   Converts one sign-magnitude operand into a SUM_W-bit two's complement
//   value. The block is purely combinational.
//   Ports:
//     mag_i  [WIDTH-1:0]  unsigned magnitude
//     sign_i              sign (0 = positive, 1 = negative)
//     tc_o   [SUM_W-1:0]  signed two's complement value
// ----------------------------------------------------------------------------
module sm_to_tc
    import signed_adder_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int SUM_W = sum_width(WIDTH)
) (
    input  logic [WIDTH-1:0]        mag_i,
    input  logic                    sign_i,
    output logic signed [SUM_W-1:0] tc_o
);

    // The magnitude is zero-extended to HELPER_W bits so the helper always
    // sees a non-negative value. The result is then narrowed back to SUM_W
    // bits. This is lossless because |value| < 2^WIDTH fits in SUM_W signed
    // bits.
    assign tc_o = SUM_W'(sm_to_tc_fn(HELPER_W'(mag_i), sign_i));

endmodule

// File: rtl/signed_adder.sv
// ----------------------------------------------------------------------------
// signed_adder
//   Adds two sign-magnitude operands and registers the signed two's
//   complement sum. The result appears one cycle after the operands are
//   sampled. The result is WIDTH + 2 bits wide, so it never overflows.
//   Ports:
//     Clk              rising-edge clock
//     Reset            synchronous reset, active-high; clears Sum
//     A   [WIDTH-1:0]  magnitude of operand A
//     B   [WIDTH-1:0]  magnitude of operand B
//     S0               sign of A (1 = negative)
//     S1               sign of B (1 = negative)
//     Sum [SUM_W-1:0]  registered signed sum, two's complement
// ----------------------------------------------------------------------------
module signed_adder
    import signed_adder_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int SUM_W = sum_width(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S0,
    input  logic             S1,
    output logic [SUM_W-1:0] Sum
);

    logic signed [SUM_W-1:0] a_tc;
    logic signed [SUM_W-1:0] b_tc;
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_q;

    // ---- operand conversion (combinational) ----
    sm_to_tc #(
        .WIDTH (WIDTH)
    ) u_conv_a (
        .mag_i  (A),
        .sign_i (S0),
        .tc_o   (a_tc)
    );

    sm_to_tc #(
        .WIDTH (WIDTH)
    ) u_conv_b (
        .mag_i  (B),
        .sign_i (S1),
        .tc_o   (b_tc)
    );

    // The sum is at most 2*(2^WIDTH - 1) in magnitude, which fits in SUM_W
    // signed bits, so a plain same-width add is exact.
    always_comb begin
        sum_d = a_tc + b_tc;
    end

    // ---- output register ----
    // The spec requires Sum to clear on reset, so this data register is reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign Sum = sum_q;

endmodule

// File: tb/tb_signed_adder.sv
// ----------------------------------------------------------------------------
// tb_signed_adder
//   Self-checking bench for signed_adder (WIDTH = 4, so Sum is 6 bits).
//   The bench checks directed scenarios against literal values. It then runs
//   randomized traffic against an integer model of the sign-magnitude sum.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_signed_adder;

    localparam int W  = 4;
    localparam int SW = W + 2;

    logic          Clk;
    logic          Reset;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          S0;
    logic          S1;
    logic [SW-1:0] Sum;

    int checks;
    int errors;

    // Reference model state: the value Sum must hold after the last edge.
    int model_sum;
    bit model_valid;

    signed_adder #(
        .WIDTH (W)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .A     (A),
        .B     (B),
        .S0    (S0),
        .S1    (S1),
        .Sum   (Sum)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int dut_sum();
        logic signed [SW-1:0] s;
        s = $signed(Sum);
        return int'(s);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Integer model: each operand is +mag or -mag, the operands are added,
    // and reset forces zero. Inputs are driven #1 after an edge, so they are
    // stable here.
    always @(posedge Clk) begin
        int av;
        int bv;
        av = S0 ? -int'(A) : int'(A);
        bv = S1 ? -int'(B) : int'(B);
        model_sum   <= Reset ? 0 : av + bv;
        model_valid <= 1'b1;
    end

    // Compare the DUT with the model on every falling edge once the model
    // holds a value.
    always @(negedge Clk) begin
        if (model_valid) check("model", dut_sum(), model_sum);
    end

    // Drive one set of inputs and step past the following rising edge.
    task automatic apply(input bit rst, input int a, input int b,
                         input bit s0, input bit s1);
        Reset = rst;
        A     = W'(a);
        B     = W'(b);
        S0    = s0;
        S1    = s1;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_valid = 1'b0;
        model_sum   = 0;
        Reset = 1'b1; A = '0; B = '0; S0 = 1'b0; S1 = 1'b0;
        #2;

        // Scenario 1: reset wins over operands of any sign.
        apply(1, 12, 9, 1, 0);
        check("reset_sum", dut_sum(), 0);
        apply(1, 12, 9, 0, 1);
        check("reset_sum_b", dut_sum(), 0);

        // Scenario 2: the first edge after reset loads the sum.
        apply(0, 12, 9, 0, 0);
        check("pos_pos", dut_sum(), 21);

        // Scenario 3: mixed signs.
        apply(0, 12, 9, 1, 0);
        check("neg_pos", dut_sum(), -3);
        check("neg_pos_bits", int'(Sum), 61);   // 6'b111101
        apply(0, 12, 9, 0, 1);
        check("pos_neg", dut_sum(), 3);

        // Scenario 4: both operands negative, then the range extremes.
        apply(0, 12, 9, 1, 1);
        check("neg_neg", dut_sum(), -21);
        apply(0, 15, 15, 1, 1);
        check("min_sum", dut_sum(), -30);
        check("min_bits", int'(Sum), 34);       // 6'b100010
        apply(0, 15, 15, 0, 0);
        check("max_sum", dut_sum(), 30);

        // Held inputs give a constant Sum.
        apply(0, 15, 15, 0, 0);
        check("held", dut_sum(), 30);

        // Scenario 5: negative zero behaves as zero.
        apply(0, 0, 5, 1, 0);
        check("neg_zero_a", dut_sum(), 5);
        apply(0, 7, 0, 0, 1);
        check("neg_zero_b", dut_sum(), 7);
        apply(0, 0, 0, 1, 1);
        check("neg_zero_both", dut_sum(), 0);

        // Scenario 6: a one-cycle reset between two valid operations.
        apply(0, 12, 9, 0, 0);
        check("pre_reset", dut_sum(), 21);
        apply(1, 12, 9, 0, 0);
        check("mid_reset", dut_sum(), 0);
        apply(0, 12, 9, 1, 0);
        check("post_reset", dut_sum(), -3);

        // Randomized traffic with an occasional reset; the compare process
        // checks every cycle against the model.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        @(negedge Clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_adder.md
SIGNED_ADDER -- requirements
Module: signed_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the magnitude width of each operand.
REQ-002 The block SHALL derive constant SUM_W = WIDTH+2, the width of the signed result.
REQ-003 The block SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous reset, active-high.
REQ-005 The block SHALL have port A, input, WIDTH bits: unsigned magnitude of operand A.
REQ-006 The block SHALL have port B, input, WIDTH bits: unsigned magnitude of operand B.
REQ-007 The block SHALL have port S0, input, 1 bit: sign of A (0 = positive, 1 = negative).
REQ-008 The block SHALL have port S1, input, 1 bit: sign of B (0 = positive, 1 = negative).
REQ-009 The block SHALL have port Sum, output, SUM_W bits, signed two's complement: registered result.

Function
REQ-010 Each operand SHALL be treated as sign-magnitude and converted to SUM_W-bit two's complement: +mag when sign=0, -mag when sign=1.
REQ-011 On every rising Clk edge with Reset=0, Sum SHALL load (S0 ? -A : A) + (S1 ? -B : B).
REQ-012 Latency SHALL be exactly one cycle: inputs sampled at edge N appear on Sum after edge N, with no combinational path from inputs to Sum.
REQ-013 The result range SHALL be -(2*(2^WIDTH-1)) .. +(2*(2^WIDTH-1)), which is -30..+30 for WIDTH=4. SUM_W SHALL hold every result without overflow, so no overflow flag exists.
REQ-014 A zero magnitude with sign=1 (negative zero) SHALL be treated as 0.
REQ-015 The block SHALL have no handshake: a new result is produced every cycle, and held inputs yield a constant Sum.
REQ-016 Mixed signs SHALL yield the signed difference, and a negative result SHALL be properly sign-extended across all SUM_W bits.
REQ-017 X/Z on inputs is outside the contract; no detection is required.

Reset
REQ-018 While Reset=1 at a rising Clk edge, Sum SHALL load 0, regardless of A, B, S0 and S1.
REQ-019 Reset SHALL take priority over computation; asserting Reset mid-stream SHALL force Sum=0 from the next edge.
REQ-020 The first edge after Reset is deasserted SHALL load the sum of the inputs present at that edge.
REQ-021 Sum is undefined before the first clock edge; no asynchronous behaviour SHALL exist.

Structure
REQ-022 WIDTH default and the SUM_W derivation SHALL live in a shared package (signed_adder_pkg), together with a helper that converts sign-magnitude to two's complement.
REQ-023 One sub-module, sm_to_tc (sign-magnitude to SUM_W-bit two's complement), SHALL be instantiated twice, once per operand.
REQ-024 The adder and the output register SHALL reside in signed_adder.

Verification
REQ-025 Scenario 1: Reset=1, A=12, B=9, any signs, clock -> Sum=0.
REQ-026 Scenario 2: Reset=0, A=12, B=9, S0=0, S1=0 -> Sum=+21 one cycle later.
REQ-027 Scenario 3: A=12, B=9, S0=1, S1=0 -> Sum=-3 (6'b111101); then S0=0, S1=1 -> Sum=+3.
REQ-028 Scenario 4: A=12, B=9, S0=1, S1=1 -> Sum=-21; then A=15, B=15, both negative -> Sum=-30; then both positive -> Sum=+30.
REQ-029 Scenario 5: A=0, S0=1, B=5, S1=0 -> Sum=+5 (negative zero is harmless).
REQ-030 Scenario 6: Reset asserted for one cycle between two valid operations -> Sum=0 for exactly that cycle, then resumes with the correct value.
